lu_result_gate: RTL

- Sits directly downstream of the packet preprocessor / flow-table pair in openflow_datapath.
- Holds each packet at the head of the preprocessor's output AXI-Stream until the flow table returns the lookup result for that packet.
- Then either forwards the packet with the destination-port field of tuser rewritten, or silently discards it.
- Lookup results arrive strictly in packet order and are queued in an internal result FIFO.

---
 rtl/lu_result_gate.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/lu_result_gate.sv
// lu_result_gate
//   Holds each packet at the head of the preprocessor output stream until the
//   flow table has returned that packet's lookup result, then either forwards
//   the packet with the destination-port field of tuser rewritten or discards
//   it. Lookup results arrive in packet order and are queued in a small FIFO.
//
// Optional build macro:
//   LU_RESULT_GATE_STATS_EN - when defined, the fwd/miss/drop packet counters
//   are built; when undefined the three counter ports are tied to 0.
//
// Ports:
//   asclk, aresetn            clock, synchronous active-low reset
//   s_axis_*                  packet stream from the preprocessor
//   res_valid/hit/drop/dport  one-cycle lookup-result strobe from the flow table
//   m_axis_*                  forwarded packet stream
//   res_overflow              sticky: a result was lost because the FIFO was full
//   fwd/miss/drop_pkt_cnt     packet statistics (wrap modulo 2^DATA_WIDTH)
//
// Handshake: a beat moves on either stream only in a cycle where tvalid and
// tready are both high; tvalid never depends on tready from the same side,
// and in FWD the input ready is the output ready, so data passes through with
// zero cycles of latency inside a packet.
//
// The FSM state is kept in the signal 'state' (IDLE/FWD/DROP) for probing.

module lu_result_gate #(
  parameter int          C_AXIS_DATA_WIDTH  = 64,
  parameter int          C_AXIS_TUSER_WIDTH = 128,
  parameter int          C_AXIS_DPT_POS     = 24,
  parameter logic [7:0]  MISS_DPORT         = 8'h02,
  parameter int          RES_DEPTH_BITS     = 3,
  parameter int          DATA_WIDTH         = 32
) (
  input  logic                              asclk,
  input  logic                              aresetn,

  input  logic [C_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]    s_axis_tstrb,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
  input  logic                              s_axis_tvalid,
  input  logic                              s_axis_tlast,
  output logic                              s_axis_tready,

  input  logic                              res_valid,
  input  logic                              res_hit,
  input  logic                              res_drop,
  input  logic [7:0]                        res_dport,

  output logic [C_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]    m_axis_tstrb,
  output logic [C_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,

  output logic                              res_overflow,
  output logic [DATA_WIDTH-1:0]             fwd_pkt_cnt,
  output logic [DATA_WIDTH-1:0]             miss_pkt_cnt,
  output logic [DATA_WIDTH-1:0]             drop_pkt_cnt
);

  localparam int RES_DEPTH = 1 << RES_DEPTH_BITS;
  localparam logic [RES_DEPTH_BITS:0] PTR_ONE = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // ---------------------------------------------------------------------------
  // Result FIFO: entry = {hit, drop, dport}. Pointers carry one extra wrap bit
  // so full and empty are distinguishable without a separate count.
  // ---------------------------------------------------------------------------
  logic [9:0]                res_mem [RES_DEPTH];
  logic [RES_DEPTH_BITS:0]   wr_ptr;
  logic [RES_DEPTH_BITS:0]   rd_ptr;
  logic                      fifo_empty;
  logic                      fifo_full;
  logic                      res_push;
  logic                      res_pop;
  logic [9:0]                head;
  logic                      head_hit;
  logic                      head_drop;
  logic [7:0]                head_dport;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[RES_DEPTH_BITS] != rd_ptr[RES_DEPTH_BITS]) &&
                      (wr_ptr[RES_DEPTH_BITS-1:0] == rd_ptr[RES_DEPTH_BITS-1:0]);

  assign head       = res_mem[rd_ptr[RES_DEPTH_BITS-1:0]];
  assign head_hit   = head[9];
  assign head_drop  = head[8];
  assign head_dport = head[7:0];

  // The decision is taken in IDLE once a packet is waiting and a result is
  // queued. The FIFO is not fall-through, so a result pushed this cycle is
  // only visible next cycle.
  assign res_pop  = (state == ST_IDLE) && s_axis_tvalid && !fifo_empty;

  // A push into a full FIFO is still accepted when the head leaves in the
  // same cycle; otherwise the result is lost and flagged.
  assign res_push = res_valid && (!fifo_full || res_pop);

  always_ff @(posedge asclk) begin
    if (res_push) begin
      res_mem[wr_ptr[RES_DEPTH_BITS-1:0]] <= {res_hit, res_drop, res_dport};
    end
  end

  always_ff @(posedge asclk) begin
    if (!aresetn) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      res_overflow <= 1'b0;
    end else begin
      if (res_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (res_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (res_valid && fifo_full && !res_pop) res_overflow <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered destination port for the packet currently being forwarded.
  // ---------------------------------------------------------------------------
  logic [7:0] dport_q;

  always_ff @(posedge asclk) begin
    if (!aresetn) begin
      dport_q <= 8'h00;
    end else if (res_pop) begin
      dport_q <= head_hit ? head_dport : MISS_DPORT;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  logic beat_acc;
  assign beat_acc = s_axis_tvalid && s_axis_tready;

  always_ff @(posedge asclk) begin
    if (!aresetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (res_pop) begin
          state_nxt = (head_hit && head_drop) ? ST_DROP : ST_FWD;
        end
      end
      ST_FWD: begin
        if (beat_acc && s_axis_tlast) state_nxt = ST_IDLE;
      end
      ST_DROP: begin
        if (beat_acc && s_axis_tlast) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs are forced low while reset is asserted so nothing
  // moves in the reset cycle even before the state register has cleared.
  always_comb begin
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    if (aresetn) begin
      case (state)
        ST_FWD: begin
          s_axis_tready = m_axis_tready;
          m_axis_tvalid = s_axis_tvalid;
          m_axis_tlast  = s_axis_tlast;
        end
        ST_DROP: begin
          s_axis_tready = 1'b1;
        end
        default: begin
          s_axis_tready = 1'b0;
        end
      endcase
    end
  end

  assign m_axis_tdata = s_axis_tdata;
  assign m_axis_tstrb = s_axis_tstrb;

  always_comb begin
    m_axis_tuser = s_axis_tuser;
    m_axis_tuser[C_AXIS_DPT_POS +: 8] = dport_q;
  end

  // ---------------------------------------------------------------------------
  // Statistics. Hit/miss counts move in the decision cycle; drops are counted
  // when the last beat of the discarded packet has been consumed.
  // ---------------------------------------------------------------------------
`ifdef LU_RESULT_GATE_STATS_EN
  localparam logic [DATA_WIDTH-1:0] CNT_ONE = 1;

  always_ff @(posedge asclk) begin
    if (!aresetn) begin
      fwd_pkt_cnt  <= '0;
      miss_pkt_cnt <= '0;
      drop_pkt_cnt <= '0;
    end else begin
      if (res_pop && head_hit && !head_drop) fwd_pkt_cnt  <= fwd_pkt_cnt + CNT_ONE;
      if (res_pop && !head_hit)              miss_pkt_cnt <= miss_pkt_cnt + CNT_ONE;
      if ((state == ST_DROP) && beat_acc && s_axis_tlast) begin
        drop_pkt_cnt <= drop_pkt_cnt + CNT_ONE;
      end
    end
  end
`else
  assign fwd_pkt_cnt  = '0;
  assign miss_pkt_cnt = '0;
  assign drop_pkt_cnt = '0;
`endif

endmodule
